// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM state encoding and
// handshake levels used by EX and the divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// EX <-> divider handshake bundle. EX is the master; the divider is the slave.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring division iteration on the {remainder, dividend/quotient}
// shift register: shift left, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  part_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  part_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   diff;
    // The top bit is always 0 between steps (remainder < divisor), so the
    // shift can drop it.
    logic             unused_msb;

    assign unused_msb = part_i[2*WIDTH];

    always_comb begin
        shifted = {part_i[2*WIDTH-1:0], 1'b0};
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};
        part_o  = shifted;
        if (!diff[WIDTH]) begin
            part_o = {diff, shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, with divide-by-zero
// detection, annul and a start/ready handshake. result_o = {remainder, quotient}.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH:0]    part_q, part_d, part_step;
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic                a_neg, b_neg;
    logic [WIDTH-1:0]    mag_a, mag_b, quo, rem;

    // Operands are reduced to magnitudes; signs are reapplied at the end.
    assign a_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign b_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign mag_a = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign mag_b = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign quo   = negq_q ? -part_q[WIDTH-1:0]       : part_q[WIDTH-1:0];
    assign rem   = negr_q ? -part_q[2*WIDTH-1:WIDTH] : part_q[2*WIDTH-1:WIDTH];

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_i    (part_q),
        .divisor_i (dvs_q),
        .part_o    (part_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;

        if (bus.annul_i) begin
            state_d  = DIV_FREE;
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = '0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                    if (bus.start_i == DIV_START) begin
                        part_d  = {{(WIDTH+1){1'b0}}, mag_a};
                        dvs_d   = mag_b;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        cnt_d   = '0;
                        state_d = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
                DIV_ON: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        result_d = {rem, quo};
                        ready_d  = DIV_RESULT_READY;
                        state_d  = DIV_END;
                    end else begin
                        part_d = part_step;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_STOP) begin
                        state_d  = DIV_FREE;
                        ready_d  = DIV_RESULT_NOT_READY;
                        result_d = '0;
                    end
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            part_q   <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = (state_q == DIV_ON) || (state_q == DIV_BYZERO);

endmodule

// File: tb/tb_div_iter.sv
// Directed + randomized bench for div_iter at WIDTH=32 and WIDTH=16, checked
// against an arithmetic reference model of signed/unsigned division.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst;
    int   npass = 0;
    int   nfail = 0;
    int   ntot  = 0;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) b32 ();
    div_iter_if #(.WIDTH(16)) b16 ();

    div_iter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    div_iter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(int w, logic st, logic sg, logic an, logic [31:0] a, logic [31:0] b);
        if (w == 32) begin
            b32.start_i = st; b32.signed_i = sg; b32.annul_i = an;
            b32.opdata1_i = a; b32.opdata2_i = b;
        end else begin
            b16.start_i = st; b16.signed_i = sg; b16.annul_i = an;
            b16.opdata1_i = a[15:0]; b16.opdata2_i = b[15:0];
        end
    endtask

    function automatic logic rdy(int w);
        return (w == 32) ? b32.ready_o : b16.ready_o;
    endfunction

    function automatic logic bsy(int w);
        return (w == 32) ? b32.busy_o : b16.busy_o;
    endfunction

    function automatic logic [63:0] res(int w);
        return (w == 32) ? b32.result_o : {32'b0, b16.result_o};
    endfunction

    // Truncating division on w-bit values; {rem, quo} packed as the DUT does.
    function automatic logic [63:0] model(int w, bit sg, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (w == 16) begin
            a = {16'b0, a[15:0]};
            b = {16'b0, b[15:0]};
        end
        if (b == 32'd0) return 64'd0;
        sa = {32'b0, a};
        sb = {32'b0, b};
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        q  = sa / sb;
        r  = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return (w == 32) ? {rr, qq} : {32'b0, rr[15:0], qq[15:0]};
    endfunction

    task automatic run(int w, bit sg, logic [31:0] a, logic [31:0] b, int hold, string tag);
        logic [63:0] exp;
        int e, nb;
        bit bz, both;
        exp  = model(w, sg, a, b);
        bz   = (w == 32) ? (b == 32'd0) : (b[15:0] == 16'd0);
        @(negedge clk);
        drive(w, 1'b1, sg, 1'b0, a, b);
        e = -1; nb = 0; both = 1'b0;
        do begin
            @(negedge clk);
            e++;
            // operands must be ignored once the start edge has passed
            if (e == 0) drive(w, 1'b1, sg, 1'b0, $urandom, $urandom);
            if (rdy(w) && bsy(w)) both = 1'b1;
            if (bsy(w)) nb++;
        end while (!rdy(w) && e < 200);
        chk({tag, " latency"}, e, bz ? 1 : w + 1);
        chk({tag, " busy cycles"}, nb, bz ? 1 : w + 1);
        chk({tag, " busy&ready"}, both, 0);
        chk({tag, " result"}, res(w), exp);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, " hold ready"}, rdy(w), 1);
            chk({tag, " hold result"}, res(w), exp);
        end
        drive(w, 1'b0, sg, 1'b0, a, b);
        @(negedge clk);
        chk({tag, " drop ready"}, rdy(w), 0);
        chk({tag, " drop result"}, res(w), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        rst = 1'b0;
        drive(32, 0, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset result", b32.result_o, 0);
        chk("reset ready", b32.ready_o, 0);
        chk("reset busy", b32.busy_o, 0);
        rst = 1'b1;

        run(32, 0, 100, 7, 0, "u 100/7");
        run(32, 1, -7, 2, 0, "s -7/2");
        run(32, 1, 7, -2, 0, "s 7/-2");
        run(32, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s overflow");
        run(32, 0, 32'hFFFF_FFFF, 1, 0, "u max/1");
        run(32, 0, 5, 0, 0, "div0");
        run(32, 1, 1234, 10, 5, "end hold");

        // annul during iteration 10, then a fresh request
        @(negedge clk);
        drive(32, 1, 0, 0, 1000, 3);
        repeat (11) @(negedge clk);
        drive(32, 0, 0, 1, 1000, 3);
        @(negedge clk);
        chk("annul busy", b32.busy_o, 0);
        chk("annul ready", b32.ready_o, 0);
        chk("annul result", b32.result_o, 0);
        drive(32, 0, 0, 0, 0, 0);
        run(32, 0, 9, 3, 0, "after annul 9/3");

        // synchronous reset mid-operation
        @(negedge clk);
        drive(32, 1, 1, 0, -1000, 7);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        drive(32, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst busy", b32.busy_o, 0);
        chk("midrst ready", b32.ready_o, 0);
        chk("midrst result", b32.result_o, 0);
        rst = 1'b1;
        run(32, 1, -100, 7, 0, "after rst");

        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            if (i % 5 == 4)              rb = 32'd0;
            else if (i % 3 == 0)         rb = $urandom_range(1, 20);
            else if (i % 3 == 1)         rb = -$urandom_range(1, 20);
            else                         rb = $urandom;
            run(32, rs, ra, rb, 0, "rand32");
        end

        run(16, 0, 100, 7, 0, "w16 100/7");
        run(16, 1, 32'h8000, 32'hFFFF, 0, "w16 overflow");
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom_range(1, 65535);
            run(16, rs, ra, rb, 0, "rand16");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
